conv1d_stride_layer: RTL
========================

# conv1d_stride_layer

Parametrised 1-D convolutional layer and successor to the single-channel sliding-window conv layer. It accepts one multi-channel input sample per handshake and runs N_KERNELS kernels in parallel. The window advances by a configurable STRIDE, with a fixed-point saturating MAC and optional ReLU. It sits between the input sample streamer and the dense layers, using ready/valid on both sides and a load-while-idle weight/bias port.

## Interface
- INPUT_LAYER_HEIGHT, 64, samples per frame (H)
- KERNEL_HEIGHT, 5, samples per window (K); K ≤ H
- IN_CHANNELS, 2, words per input sample (C)
- N_KERNELS, 8, parallel kernels / output words
- STRIDE, 1, samples the window advances per output; 1 ≤ STRIDE
- WORD_SIZE, 16, signed word width
- N_SIZE, 12, fractional bits
- RELU, 0, 1 = clamp negative results to 0
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset
- start_i  in  1  begin a frame (sampled in eIDLE only)
- busy_o  out  1  high in every state except eIDLE
- wen_i  in  1  weight/bias write strobe
- mem_addr_i  in  $clog2(N_KERNELS)+$clog2(C*K+1)  {kernel index, slot}; slot 0 = bias, slot 1+k*C+c = weight for tap k (0 = oldest sample), channel c
- mem_data_i  in  WORD_SIZE  write data
- valid_i  in  1  input sample valid
- yumi_o  out  1  input sample consumed this cycle
- data_i  in  C×WORD_SIZE  one sample, channel c in slice c
- valid_o  out  1  output vector valid
- ready_i  in  1  downstream ready
- data_o  out  N_KERNELS×WORD_SIZE  one result per kernel

## Operation
- FSM states: eIDLE, eFILL, eCOMPUTE, eOUT, eSTRIDE, eDRAIN.
- eIDLE: yumi_o=0, valid_o=0.
  - Writes with wen_i=1 update the register file.
  - start_i → eFILL, resetting all counters.
- Writes are ignored outside eIDLE. Out-of-range kernel index or slot is ignored.
- eFILL: yumi_o=valid_i. Each handshake shifts data_i into a K-deep sample window. After K handshakes → eCOMPUTE.
- eCOMPUTE: yumi_o=0. One tap per cycle for T=C*K cycles.
  - Cycle 0: acc = bias<<N_SIZE + w·x.
  - Later cycles: acc += w·x.
  - Accumulator width: 2*WORD_SIZE+$clog2(T+1)+1, signed.
  - Then → eOUT.
- Result per kernel:
  - acc arithmetically shifted right by N_SIZE (truncation toward −∞).
  - Saturated to [−2^(WORD_SIZE−1), 2^(WORD_SIZE−1)−1].
  - If RELU=1, negative results become 0.
  - Registered into data_o.
- eOUT: valid_o=1, data_o held stable until ready_i. On handshake, out_count increments.
  - out_count = N_OUT = (H−K)/STRIDE+1 → eDRAIN if samples consumed < H, else eIDLE.
  - Otherwise → eSTRIDE.
- eSTRIDE: yumi_o=valid_i. Accept STRIDE samples, shifting the window; STRIDE > K is legal. Then → eCOMPUTE.
- eDRAIN: yumi_o=valid_i. Consume and discard samples until H samples in total have been accepted, then → eIDLE.
- start_i is ignored outside eIDLE.

## Timing
- Reset (reset_n_i=0 at a clock edge) forces:
  - state eIDLE
  - valid_o=0, yumi_o=0, busy_o=0, data_o=0
  - counters and window cleared
- Weights are not cleared by reset.
- Reset mid-frame aborts the frame; no partial output is emitted.
- valid_i held high, start_i at cycle 0:
  - eFILL handshakes occur at cycles 1..K.
  - eCOMPUTE occupies cycles K+1..K+T.
  - valid_o rises at cycle K+T+1.
- Each subsequent output follows the previous output handshake by STRIDE+T+1 cycles, minimum.
- yumi_o and valid_o are never high in the same cycle.
- yumi_o depends combinationally on valid_i only. valid_o is registered state.
- valid_i gaps stall eFILL/eSTRIDE/eDRAIN without losing counts.
- A wen_i write and start_i in the same eIDLE cycle: the write is applied, and the frame uses the new value.

## Test plan
- Basic (H=8, K=3, C=2, STRIDE=1, N_SIZE=12): all weights 0x1000, bias 0, all inputs 0x0800 → 6 outputs of 0x3000 on every kernel. First valid_o at cycle 10.
- Stride/drain (H=8, K=3, STRIDE=2): inputs 1.0..8.0 on channel 0, channel-0 weights 1.0, others 0 → outputs 6.0, 12.0, 18.0. The 8th sample is consumed in eDRAIN; busy_o falls after it.
- Saturation/ReLU: inputs 0x7FFF, weights 0x7FFF → 0x7FFF. Weights 0x8000 with RELU=0 → 0x8000; with RELU=1 → 0x0000.
- Backpressure: ready_i low for 5 cycles in eOUT → data_o constant, yumi_o=0, no extra samples consumed. The output handshakes on the 6th cycle.
- Reset mid-compute: assert reset_n_i=0 during eCOMPUTE → next cycle valid_o=0, busy_o=0. A new start_i produces correct results from the retained weights.
- Write protection: wen_i pulses during eFILL with different data → ignored. Results match the eIDLE-loaded weights.

Source files
------------

// File: rtl/conv1d_stride_layer.sv
// conv1d_stride_layer: multi-channel 1-D convolution with N_KERNELS parallel kernels and a
// configurable stride. It uses a fixed-point saturating MAC with one tap per cycle and an
// optional ReLU.
//
// Ports:
//   clk_i, reset_n_i       clock, synchronous active-low reset
//   start_i / busy_o       frame start (accepted only when idle) / not-idle indicator
//   wen_i, mem_addr_i,     weight/bias write port, idle only;
//   mem_data_i             address = {kernel, slot}, slot 0 = bias, slot 1+k*C+c = weight
//   valid_i, yumi_o,       input sample stream, C words per sample
//   data_i
//   valid_o, ready_i,      output vector stream, one word per kernel
//   data_o
module conv1d_stride_layer #(
  parameter int unsigned INPUT_LAYER_HEIGHT = 64,
  parameter int unsigned KERNEL_HEIGHT      = 5,
  parameter int unsigned IN_CHANNELS        = 2,
  parameter int unsigned N_KERNELS          = 8,
  parameter int unsigned STRIDE             = 1,
  parameter int unsigned WORD_SIZE          = 16,
  parameter int unsigned N_SIZE             = 12,
  parameter int unsigned RELU               = 0
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  start_i,
  output logic                                  busy_o,
  input  logic                                  wen_i,
  input  logic [$clog2(N_KERNELS)+$clog2(IN_CHANNELS*KERNEL_HEIGHT+1)-1:0] mem_addr_i,
  input  logic [WORD_SIZE-1:0]                  mem_data_i,
  input  logic                                  valid_i,
  output logic                                  yumi_o,
  input  logic [IN_CHANNELS*WORD_SIZE-1:0]      data_i,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic [N_KERNELS*WORD_SIZE-1:0]        data_o
);

  localparam int unsigned H     = INPUT_LAYER_HEIGHT;
  localparam int unsigned K     = KERNEL_HEIGHT;
  localparam int unsigned C     = IN_CHANNELS;
  localparam int unsigned T     = C * K;
  localparam int unsigned N_OUT = (H - K) / STRIDE + 1;
  localparam int unsigned KW    = $clog2(N_KERNELS);
  localparam int unsigned SW    = $clog2(T + 1);
  localparam int unsigned AW    = 2 * WORD_SIZE + $clog2(T + 1) + 1;
  localparam int unsigned IW    = $clog2(H + 1);
  localparam int unsigned OW    = $clog2(N_OUT + 1);
  localparam int unsigned STW   = $clog2(STRIDE + 1);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {eIDLE, eFILL, eCOMPUTE, eOUT, eSTRIDE, eDRAIN} state_e;

  state_e r_state, w_next;

  // Weights are deliberately outside the reset domain so they survive a frame abort.
  logic signed [WORD_SIZE-1:0] r_mem [N_KERNELS][T+1];
  // Window flattened tap-major: entry k*C+c is tap k (0 = oldest), channel c, so the
  // tap counter indexes the window and (tap+1) indexes the weight slot directly.
  logic signed [WORD_SIZE-1:0] r_win [T];
  logic signed [AW-1:0]        r_acc [N_KERNELS];
  logic [SW-1:0]               r_tap;
  logic [IW-1:0]               r_in_cnt;
  logic [OW-1:0]               r_out_cnt;
  logic [STW-1:0]              r_str_cnt;
  logic [N_KERNELS*WORD_SIZE-1:0] r_data;

  logic [KW-1:0]               w_kidx;
  logic [SW-1:0]               w_slot;
  logic [SW-1:0]               w_rd_slot;
  logic                        w_last_tap;
  logic                        w_last_str;
  logic                        w_in_hs;
  logic                        w_out_hs;
  logic signed [2*WORD_SIZE-1:0] w_x;
  logic signed [2*WORD_SIZE-1:0] w_prod     [N_KERNELS];
  logic signed [AW-1:0]          w_base     [N_KERNELS];
  logic signed [AW-1:0]          w_acc_next [N_KERNELS];
  logic signed [AW-1:0]          w_shift    [N_KERNELS];
  logic [WORD_SIZE-1:0]          w_res      [N_KERNELS];

  assign w_kidx     = mem_addr_i[KW+SW-1:SW];
  assign w_slot     = mem_addr_i[SW-1:0];
  assign w_rd_slot  = r_tap + SW'(1);
  assign w_last_tap = (r_tap == SW'(T - 1));
  assign w_last_str = (r_str_cnt == STW'(STRIDE - 1));
  assign w_in_hs    = yumi_o;
  assign w_out_hs   = valid_o & ready_i;
  assign data_o     = r_data;

  always_ff @(posedge clk_i) begin
    if (wen_i && (r_state == eIDLE) && (32'(w_kidx) < N_KERNELS) && (32'(w_slot) <= T)) begin
      r_mem[w_kidx][w_slot] <= mem_data_i;
    end
  end

  // MAC datapath: first tap seeds the accumulator with the bias aligned to the product scale.
  always_comb begin
    w_x = (2*WORD_SIZE)'(r_win[r_tap]);
    for (int n = 0; n < N_KERNELS; n++) begin
      w_prod[n]     = (2*WORD_SIZE)'(r_mem[n][w_rd_slot]) * w_x;
      w_base[n]     = (r_tap == '0) ? (AW'(r_mem[n][0]) <<< N_SIZE) : r_acc[n];
      w_acc_next[n] = w_base[n] + AW'(w_prod[n]);
      w_shift[n]    = w_acc_next[n] >>> N_SIZE;
      if (w_shift[n] > SAT_MAX) begin
        w_res[n] = {1'b0, {(WORD_SIZE-1){1'b1}}};
      end else if (w_shift[n] < SAT_MIN) begin
        w_res[n] = {1'b1, {(WORD_SIZE-1){1'b0}}};
      end else begin
        w_res[n] = w_shift[n][WORD_SIZE-1:0];
      end
      if ((RELU != 0) && w_res[n][WORD_SIZE-1]) begin
        w_res[n] = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= eIDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    yumi_o  = 1'b0;
    valid_o = 1'b0;
    busy_o  = 1'b1;
    case (r_state)
      eIDLE: begin
        busy_o = 1'b0;
        if (start_i) w_next = eFILL;
      end
      eFILL: begin
        yumi_o = valid_i;
        if (valid_i && (r_in_cnt == IW'(K - 1))) w_next = eCOMPUTE;
      end
      eCOMPUTE: begin
        if (w_last_tap) w_next = eOUT;
      end
      eOUT: begin
        valid_o = 1'b1;
        if (ready_i) begin
          if (r_out_cnt == OW'(N_OUT - 1)) begin
            w_next = (r_in_cnt < IW'(H)) ? eDRAIN : eIDLE;
          end else begin
            w_next = eSTRIDE;
          end
        end
      end
      eSTRIDE: begin
        yumi_o = valid_i;
        if (valid_i && w_last_str) w_next = eCOMPUTE;
      end
      eDRAIN: begin
        yumi_o = valid_i;
        if (valid_i && (r_in_cnt == IW'(H - 1))) w_next = eIDLE;
      end
      default: w_next = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_str_cnt <= '0;
      r_tap     <= '0;
      r_data    <= '0;
      for (int i = 0; i < T; i++) r_win[i] <= '0;
      for (int n = 0; n < N_KERNELS; n++) r_acc[n] <= '0;
    end else begin
      if (w_in_hs) begin
        r_in_cnt <= r_in_cnt + IW'(1);
        for (int i = 0; i < T - C; i++) r_win[i] <= r_win[i+C];
        for (int c = 0; c < C; c++) r_win[T-C+c] <= data_i[c*WORD_SIZE +: WORD_SIZE];
      end
      case (r_state)
        eIDLE: begin
          if (start_i) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_str_cnt <= '0;
            r_tap     <= '0;
          end
        end
        eCOMPUTE: begin
          for (int n = 0; n < N_KERNELS; n++) r_acc[n] <= w_acc_next[n];
          r_tap <= w_last_tap ? '0 : r_tap + SW'(1);
          if (w_last_tap) begin
            for (int n = 0; n < N_KERNELS; n++) r_data[n*WORD_SIZE +: WORD_SIZE] <= w_res[n];
          end
        end
        eOUT: begin
          if (w_out_hs) r_out_cnt <= r_out_cnt + OW'(1);
        end
        eSTRIDE: begin
          if (w_in_hs) r_str_cnt <= w_last_str ? '0 : r_str_cnt + STW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
